// File: rtl/kbd_lcd_pkg.sv
// Shared types and constants for the keyboard-to-LCD stream writer:
// drain FSM encoding, LCD command values and the PS/2 frame unpacker.
package kbd_lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRAP_CHK  = 3'd1,
        ST_CMD_START = 3'd2,
        ST_CMD_WAIT  = 3'd3,
        ST_DAT_POP   = 3'd4,
        ST_DAT_START = 3'd5,
        ST_DAT_WAIT  = 3'd6,
        ST_DONE      = 3'd7
    } drain_state_e;

    localparam logic [7:0] LCD_SET_DDRAM = 8'h80;

    // DDRAM address of column 0 for each display line
    localparam logic [7:0] LINE_BASE [4] = '{8'h00, 8'h40, 8'h14, 8'h54};

    // PS/2 sends LSB first, so data bit0 sits at frame[9] and bit7 at frame[2]
    function automatic logic [7:0] ps2_to_byte(input logic [10:0] frame);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b[i] = frame[9-i];
        end
        return b;
    endfunction

endpackage

// File: rtl/kbd_sync_fifo.sv
// Synchronous FIFO with a registered head word, so the consumer reads the
// oldest entry straight from a flop. Push at full is taken only alongside a pop.
module kbd_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             sm_clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge sm_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge sm_clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            head   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end
            // With one entry left, a simultaneous push becomes the new head
            if (do_pop) begin
                head <= (do_push && level == (AW+1)'(1)) ? din : mem[rd_ptr + 1'b1];
            end else if (do_push && empty) begin
                head <= din;
            end
        end
    end

endmodule

// File: rtl/kbd_lcd_stream_writer.sv
// Buffers PS/2 keystrokes and drains them to the LCD writer, tracking the
// cursor and inserting DDRAM set-address commands when a line fills up.
module kbd_lcd_stream_writer
    import kbd_lcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LCD_COLS   = 16,
    parameter int LCD_LINES  = 2
) (
    input  logic                          sm_clk,
    input  logic                          reset,
    input  logic [10:0]                   kbd_data,
    input  logic                          kbd_ready,
    output logic                          reset_kbd_data,
    output logic                          start_LCD_writer,
    input  logic                          LCD_writer_finished,
    output logic [7:0]                    DB,
    output logic                          is_command,
    output logic                          finish,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output drain_state_e                  state_dbg
);

    localparam int CW = $clog2(LCD_COLS + 1);

    logic [1:0]    ready_sync;
    logic          ready_prev;
    logic          ready_rise;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [7:0]    fifo_head;
    logic          wrap;
    logic [CW-1:0] col;
    logic [1:0]    line;
    logic [1:0]    line_nx;
    logic          unused_frame_bits;
    drain_state_e  state;
    drain_state_e  state_nx;

    assign unused_frame_bits = ^{kbd_data[10], kbd_data[1:0]};
    assign ready_rise        = ready_sync[1] & ~ready_prev;

    always_ff @(posedge sm_clk or negedge reset) begin
        if (!reset) begin
            ready_sync     <= '0;
            ready_prev     <= 1'b0;
            reset_kbd_data <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            ready_sync     <= {ready_sync[0], kbd_ready};
            ready_prev     <= ready_sync[1];
            reset_kbd_data <= ready_rise;
            if (ready_rise && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
        end
    end

    kbd_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sm_clk (sm_clk),
        .reset  (reset),
        .push   (ready_rise),
        .din    (ps2_to_byte(kbd_data)),
        .pop    (fifo_pop),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    // Wrap is lazy: col reaches LCD_COLS after the last column is written and
    // the address command goes out only when another character is pending.
    assign wrap    = (col == CW'(LCD_COLS));
    assign line_nx = (line == 2'(LCD_LINES - 1)) ? 2'd0 : line + 2'd1;

    always_ff @(posedge sm_clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // LCD handshake: start_LCD_writer is a one-cycle request; DB/is_command are
    // held until LCD_writer_finished is seen high in the matching wait state.
    always_comb begin
        state_nx = state;
        fifo_pop = 1'b0;
        case (state)
            ST_IDLE:      if (!fifo_empty) state_nx = ST_WRAP_CHK;
            ST_WRAP_CHK: begin
                if (wrap) begin
                    state_nx = ST_CMD_START;
                end else begin
                    fifo_pop = 1'b1;
                    state_nx = ST_DAT_START;
                end
            end
            ST_CMD_START: state_nx = ST_CMD_WAIT;
            ST_CMD_WAIT:  if (LCD_writer_finished) state_nx = ST_DAT_POP;
            ST_DAT_POP: begin
                fifo_pop = 1'b1;
                state_nx = ST_DAT_START;
            end
            ST_DAT_START: state_nx = ST_DAT_WAIT;
            ST_DAT_WAIT:  if (LCD_writer_finished) state_nx = ST_DONE;
            ST_DONE:      state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    assign start_LCD_writer = (state == ST_CMD_START) || (state == ST_DAT_START);
    assign finish           = (state == ST_DONE);
    assign state_dbg        = state;

    always_ff @(posedge sm_clk or negedge reset) begin
        if (!reset) begin
            col        <= '0;
            line       <= '0;
            DB         <= '0;
            is_command <= 1'b0;
        end else begin
            if (state == ST_WRAP_CHK && wrap) begin
                col        <= '0;
                line       <= line_nx;
                DB         <= LCD_SET_DDRAM | LINE_BASE[line_nx];
                is_command <= 1'b1;
            end else if (fifo_pop) begin
                DB         <= fifo_head;
                is_command <= 1'b0;
            end
            if (state == ST_DAT_WAIT && LCD_writer_finished) begin
                col <= col + 1'b1;
            end
        end
    end

endmodule
